// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits WAIT_CYCLES,
// then performs the access and holds the response until the initiator takes it.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state   | meaning
  // ST_IDLE | ready for a new request
  // ST_WAIT | request latched, counting down wait cycles
  // ST_RESP | response presented, waiting for rsp_ready
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic        accept, enter_resp;
  logic        cur_we, cur_err, mem_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt == 4'd0) begin
        state_nxt  = ST_RESP;
        enter_resp = 1'b1;
      end
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // With zero wait cycles the access happens on the accepting edge, so the
  // live request inputs are used instead of the latched copy.
  assign cur_we    = (state == ST_IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
  assign idx       = cur_addr[AW+1:2];
  assign mem_we    = reset && enter_resp && cur_we && !cur_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur_we) ? 32'd0 : mem[idx];
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Storage is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= cur_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic
// checked against an array model, on a WAIT_CYCLES=0 and a WAIT_CYCLES=2 instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  rv, rr;
  logic [1:0]  rq_rdy, rs_vld, rs_err;
  logic [31:0] rs_rd [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rq_rdy[0]),
    .rsp_valid(rs_vld[0]), .rsp_ready(rr[0]), .rsp_rdata(rs_rd[0]),
    .rsp_err(rs_err[0]));

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rq_rdy[1]),
    .rsp_valid(rs_vld[1]), .rsp_ready(rr[1]), .rsp_rdata(rs_rd[1]),
    .rsp_err(rs_err[1]));

  // One complete transaction on instance s; lat counts edges from the accepting edge.
  task automatic txn(input int s, input bit we, input logic [31:0] addr, wd,
                     output logic [31:0] rd, output bit er, output int lat);
    int g;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; rv[s] = 1'b1; rr[s] = 1'b0;
    g = 0;
    while (!rq_rdy[s] && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1 rv[s] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rs_vld[s] && lat < 40) begin @(negedge clk); lat++; end
    rd = rs_rd[s]; er = rs_err[s];
    rr[s] = 1'b1;
    @(posedge clk); #1 rr[s] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rv = '0; rr = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++; if (rq_rdy[s] !== 1'b1) begin failures++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", s, rq_rdy[s]); end
      checks++; if (rs_vld[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", s, rs_vld[s]); end
      checks++; if (rs_err[s] !== 1'b0) begin failures++; $display("FAIL reset_rsp_err[%0d] got=%b exp=0", s, rs_err[s]); end
      checks++; if (rs_rd[s] !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata[%0d] got=%h exp=0", s, rs_rd[s]); end
    end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; bit er; int lat;
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    txn(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; bit er; int lat;
    txn(1, 1'b1, 32'h13, 32'h1, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL misaligned_wr got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL after_misaligned got=%h exp=deadbeef", rd); end
    txn(1, 1'b0, 32'h400, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL oob_rd got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1, 1'b1, 32'h0, 32'h0000CAFE, rd, er, lat);
    txn(1, 1'b1, 32'h400, 32'hBADBAD00, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oob_wr_err got=%b exp=1", er); end
    txn(1, 1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000CAFE) begin failures++; $display("FAIL oob_wr_alias got=%h exp=0000cafe", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; bit er; int lat; int g;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; rv[1] = 1'b1; rr[1] = 1'b0;
    @(posedge clk); #1 rv[1] = 1'b0;
    g = 0;
    @(negedge clk);
    while (!rs_vld[1] && g < 20) begin @(negedge clk); g++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rs_vld[1] !== 1'b1 || rs_rd[1] !== 32'hDEADBEEF || rs_err[1] !== 1'b0 || rq_rdy[1] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got valid=%b rdata=%h err=%b ready=%b exp 1 deadbeef 0 0",
                 i, rs_vld[1], rs_rd[1], rs_err[1], rq_rdy[1]);
      end
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD; rv[1] = 1'b1;
      @(posedge clk); #1 rv[1] = 1'b0;
      @(negedge clk);
    end
    rr[1] = 1'b1;
    @(posedge clk); #1 rr[1] = 1'b0;
    checks++;
    if (rs_vld[1] !== 1'b0 || rq_rdy[1] !== 1'b1 || rs_rd[1] !== 32'd0) begin
      failures++;
      $display("FAIL stall_release got valid=%b ready=%b rdata=%h exp 0 1 0", rs_vld[1], rq_rdy[1], rs_rd[1]);
    end
    txn(1, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_pulses_ignored got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; bit er; int lat;
    txn(1, 1'b1, 32'h20, 32'hAAAAAAAA, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; rv[1] = 1'b1;
    @(posedge clk); #1 rv[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (rq_rdy[1] !== 1'b1 || rs_vld[1] !== 1'b0 || rs_rd[1] !== 32'd0) begin
      failures++;
      $display("FAIL reset_in_wait got ready=%b valid=%b rdata=%h exp 1 0 0", rq_rdy[1], rs_vld[1], rs_rd[1]);
    end
    repeat (3) begin
      @(negedge clk);
      checks++; if (rs_vld[1] !== 1'b0) begin failures++; $display("FAIL reset_no_rsp got=%b exp=0", rs_vld[1]); end
    end
    reset = 1'b1;
    txn(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hAAAAAAAA) begin failures++; $display("FAIL reset_aborts_write got=%h exp=aaaaaaaa", rd); end
  endtask

  task automatic test_reset_with_accept();
    logic [31:0] rd; bit er; int lat;
    txn(0, 1'b1, 32'h8, 32'h55555555, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h99999999; rv[0] = 1'b1; reset = 1'b0;
    @(posedge clk); #1 rv[0] = 1'b0;
    checks++; if (rs_vld[0] !== 1'b0) begin failures++; $display("FAIL reset_accept_rsp got=%b exp=0", rs_vld[0]); end
    @(negedge clk);
    reset = 1'b1;
    txn(0, 1'b0, 32'h8, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h55555555) begin failures++; $display("FAIL reset_accept_dropped got=%h exp=55555555", rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL w0_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit er; int lat;
    int acc [$];
    int rsp [$];
    logic [31:0] dat [$];
    txn(0, 1'b1, 32'h0, 32'h01010101, rd, er, lat);
    txn(0, 1'b1, 32'h4, 32'h02020202, rd, er, lat);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0; rv[0] = 1'b1; rr[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (rs_vld[0]) begin rsp.push_back(k); dat.push_back(rs_rd[0]); end
      if (rv[0] && rq_rdy[0]) acc.push_back(k);
      @(posedge clk); #1;
      if (acc.size() == 1) req_addr = 32'h4;
      if (acc.size() >= 2) rv[0] = 1'b0;
      @(negedge clk);
    end
    rr[0] = 1'b0;
    checks++;
    if (acc.size() != 2 || rsp.size() != 2) begin
      failures++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 2 2", acc.size(), rsp.size());
    end else begin
      checks++; if (rsp[0] != acc[0] + 1 || rsp[1] != acc[1] + 1) begin failures++; $display("FAIL b2b_latency got acc=%0d,%0d rsp=%0d,%0d exp rsp=acc+1", acc[0], acc[1], rsp[0], rsp[1]); end
      checks++; if (acc[1] - acc[0] != 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=2 (accept on edge after handshake)", acc[1] - acc[0]); end
      checks++; if (dat[0] !== 32'h01010101 || dat[1] !== 32'h02020202) begin failures++; $display("FAIL b2b_data got=%h,%h exp 01010101,02020202", dat[0], dat[1]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] mdl [2][256];
    bit          vld [2][256];
    logic [31:0] rd, addr, wd, exp_rd;
    bit er, we, exp_err;
    int lat, r;
    for (int s = 0; s < 2; s++) for (int w = 0; w < 256; w++) vld[s][w] = 1'b0;
    for (int n = 0; n < 80; n++) begin
      int s;
      s = n % 2;
      we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0)      addr = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
      else if (r == 1) addr = $urandom_range(256, 2000) * 4;
      else             addr = $urandom_range(0, 15) * 4;
      wd = $urandom;
      exp_err = (addr % 4 != 0) || (addr / 4 >= 256);
      txn(s, we, addr, wd, rd, er, lat);
      checks++; if (er !== exp_err) begin failures++; $display("FAIL rand_err n=%0d addr=%h got=%b exp=%b", n, addr, er, exp_err); end
      checks++; if (lat != (s == 0 ? 1 : 3)) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, (s == 0 ? 1 : 3)); end
      if (we || exp_err || vld[s][addr / 4]) begin
        exp_rd = (we || exp_err) ? 32'd0 : mdl[s][addr / 4];
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, addr, rd, exp_rd); end
      end
      if (we && !exp_err) begin mdl[s][addr / 4] = wd; vld[s][addr / 4] = 1'b1; end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_stall();
    test_reset_in_wait();
    test_reset_with_accept();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
